// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, instruction codes, register IDs,
// and the W pipeline register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] SAOK = 4'b1000;
  localparam logic [3:0] SHLT = 4'b0100;
  localparam logic [3:0] SADR = 4'b0010;
  localparam logic [3:0] SINS = 4'b0001;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP, val_e: 64'h0,
                                  val_m: 64'h0, dst_e: RNONE, dst_m: RNONE};

  function automatic logic is_aok(input logic [3:0] stat);
    return stat == SAOK;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: NREG x 64 bits, two combinational read ports,
// two synchronous write ports with the M port taking priority on collision.
module regfile
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_e_i,
  input  logic [3:0]            dst_e_i,
  input  logic [63:0]           val_e_i,
  input  logic                  we_m_i,
  input  logic [3:0]            dst_m_i,
  input  logic [63:0]           val_m_i,
  input  logic [3:0]            src_a_i,
  input  logic [3:0]            src_b_i,
  output logic [63:0]           rval_a_o,
  output logic [63:0]           rval_b_o,
  output logic [NREG-1:0][63:0] regs_o
);

  logic [63:0] regs_q [NREG];

  // Register array update: M beats E so popq %rsp keeps the loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 64'h0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m_i && (dst_m_i == 4'(i))) begin
          regs_q[i] <= val_m_i;
        end else if (we_e_i && (dst_e_i == 4'(i))) begin
          regs_q[i] <= val_e_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  // Read mux: an address with no matching entry (RNONE) reads as zero.
  always_comb begin
    rval_a_o = 64'h0;
    rval_b_o = 64'h0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a_i == 4'(i)) begin
        rval_a_o = regs_q[i];
      end else begin
        rval_a_o = rval_a_o;
      end
      if (src_b_i == 4'(i)) begin
        rval_b_o = regs_q[i];
      end else begin
        rval_b_o = rval_b_o;
      end
    end
  end

  // Display taps.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_o[i] = regs_q[i];
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W pipeline register, register file writes,
// sticky processor status and retired-instruction counter.
module writeback_stage
  import y86_pkg::*;
#(
  parameter int NREG  = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             W_stall,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       M_icode,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [3:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [63:0]      reg0,
  output logic [63:0]      reg1,
  output logic [63:0]      reg2,
  output logic [63:0]      reg3,
  output logic [63:0]      reg4,
  output logic [63:0]      reg5,
  output logic [63:0]      reg6,
  output logic [63:0]      reg7,
  output logic [63:0]      reg8,
  output logic [63:0]      reg9,
  output logic [63:0]      reg10,
  output logic [63:0]      reg11,
  output logic [63:0]      reg12,
  output logic [63:0]      reg13,
  output logic [63:0]      reg14
);

  w_reg_t                  w_q, w_d;
  logic [3:0]              pstat_q, pstat_d;
  logic                    halted_q, halted_d;
  logic [CNT_W-1:0]        ret_q, ret_d;
  logic                    wr_en_s;
  logic                    we_e_s;
  logic                    we_m_s;
  logic [NREG-1:0][63:0]   regs_s;

  assign wr_en_s = !W_stall && is_aok(w_q.stat);
  assign we_e_s  = wr_en_s && (w_q.dst_e != RNONE);
  assign we_m_s  = wr_en_s && (w_q.dst_m != RNONE);

  // Next-state for W register, sticky status and retire counter.
  always_comb begin
    w_d      = w_q;
    pstat_d  = pstat_q;
    ret_d    = ret_q;
    if (!W_stall) begin
      w_d = '{stat: m_stat, icode: M_icode, val_e: M_valE,
              val_m: m_valM, dst_e: M_dstE, dst_m: M_dstM};
    end else begin
      w_d = w_q;
    end
    // Status latches even under stall; once non-AOK it never moves again.
    if (is_aok(pstat_q)) begin
      pstat_d = w_q.stat;
    end else begin
      pstat_d = pstat_q;
    end
    if (wr_en_s && (w_q.icode != INOP) && is_aok(pstat_q)) begin
      ret_d = ret_q + CNT_W'(1);
    end else begin
      ret_d = ret_q;
    end
    halted_d = !is_aok(pstat_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= W_BUBBLE;
      pstat_q  <= SAOK;
      halted_q <= 1'b0;
      ret_q    <= '0;
    end else begin
      w_q      <= w_d;
      pstat_q  <= pstat_d;
      halted_q <= halted_d;
      ret_q    <= ret_d;
    end
  end

  regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_e_i   (we_e_s),
    .dst_e_i  (w_q.dst_e),
    .val_e_i  (w_q.val_e),
    .we_m_i   (we_m_s),
    .dst_m_i  (w_q.dst_m),
    .val_m_i  (w_q.val_m),
    .src_a_i  (d_srcA),
    .src_b_i  (d_srcB),
    .rval_a_o (d_rvalA),
    .rval_b_o (d_rvalB),
    .regs_o   (regs_s)
  );

  assign W_stat    = w_q.stat;
  assign W_icode   = w_q.icode;
  assign W_dstE    = w_q.dst_e;
  assign W_dstM    = w_q.dst_m;
  assign W_valE    = w_q.val_e;
  assign W_valM    = w_q.val_m;
  assign proc_stat = pstat_q;
  assign halted    = halted_q;
  assign retired   = ret_q;

  assign reg0  = regs_s[0];
  assign reg1  = regs_s[1];
  assign reg2  = regs_s[2];
  assign reg3  = regs_s[3];
  assign reg4  = regs_s[4];
  assign reg5  = regs_s[5];
  assign reg6  = regs_s[6];
  assign reg7  = regs_s[7];
  assign reg8  = regs_s[8];
  assign reg9  = regs_s[9];
  assign reg10 = regs_s[10];
  assign reg11 = regs_s[11];
  assign reg12 = regs_s[12];
  assign reg13 = regs_s[13];
  assign reg14 = regs_s[14];

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage Y86-64 pipeline, directly downstream of the memory stage. Holds the W pipeline register, owns the 15-entry architectural register file (combinational read ports feeding decode, synchronous write ports driven from W), and produces the sticky processor status that stops simulation. It also exposes the W-register fields that decode forwarding and PC selection consume.

## Interface
Parameters:
- `NREG`, 15: architectural registers %rax..%r14; ID 4'hF is RNONE.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `W_stall`  in  1  from control; hold W register and suppress writes.
- `m_stat`  in  4  one-hot status from memory stage (1000 AOK, 0100 HLT, 0010 ADR, 0001 INS).
- `M_icode`  in  4  instruction code in M.
- `M_valE`, `m_valM`  in  64  ALU result, loaded memory value.
- `M_dstE`, `M_dstM`  in  4  destination register IDs.
- `d_srcA`, `d_srcB`  in  4  decode read addresses.
- `d_rvalA`, `d_rvalB`  out  64  register-file read data; 0 when address is 4'hF.
- `W_stat`  out  4  registered status.
- `W_icode`, `W_dstE`, `W_dstM`  out  4  registered fields.
- `W_valE`, `W_valM`  out  64  registered values.
- `proc_stat`  out  4  sticky processor status.
- `halted`  out  1  high when `proc_stat` != AOK.
- `retired`  out  `CNT_W`  count of retired instructions.
- `reg0`..`reg14`  out  64  register-file contents, for the display path.

## Operation
- W register: on rising edge, if `!W_stall`, load {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM}; if `W_stall`, hold.
- Register write, same edge, from current W contents, enabled only when `!W_stall` and `W_stat`==AOK:
  - `W_dstE`!=4'hF: reg[W_dstE] <= `W_valE`.
  - `W_dstM`!=4'hF: reg[W_dstM] <= `W_valM`.
  - `W_dstE`==`W_dstM`!=4'hF: `W_valM` wins (popq %rsp semantics).
- Reads are combinational from the array; a read of the register being written this cycle returns the old value (decode forwarding covers W).
- Status: while `proc_stat`==AOK, `proc_stat` <= `W_stat` each edge. Once non-AOK it freezes until reset, ignoring `W_stall`.
- Retire counter: increments by 1 on an edge where a write is enabled (per the rule above) and `W_icode` != 4'h1 (nop/bubble). It wraps modulo 2^`CNT_W`. It does not increment after `halted` rises.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release): W register = bubble {stat 1000, icode 4'h1, valE 0, valM 0, dstE F, dstM F}; all registers 0; `proc_stat` 1000; `halted` 0; `retired` 0.
- Latency: an M-stage value appears on the W outputs 1 edge later and in the register file 2 edges after it is in M.
- `halted` and `proc_stat` update on the edge after the faulting instruction enters W.
- When `W_stall` and a non-AOK W_stat occur together: no register write, `proc_stat` still latches.
- If `rst_n` is asserted mid-run, all state clears immediately, regardless of `W_stall`.

## Structure
- Shared package `y86_pkg`: stat encodings (SAOK, SHLT, SADR, SINS), icode constants (IHALT..IPOPQ, INOP=4'h1), RNONE=4'hF, RRSP=4'h4.
- One sub-module, `regfile`: 15×64 array with 2 asynchronous read ports, 2 synchronous write ports, M-over-E priority, asynchronous clear, and `reg0`..`reg14` taps. The W register, status, and counter logic sit in `writeback_stage`.

## Test plan
- Reset: after reset, `W_icode`=1, `W_dstE`=F, all `regN`=0, `proc_stat`=1000, `retired`=0.
- irmovq: M_icode=3, M_valE=0x2A, M_dstE=0 (rax), stat AOK. Required: `W_valE`=0x2A after 1 edge; `reg0`=0x2A and `retired`=1 after 2 edges; `d_srcA`=0 returns 0x2A.
- Write priority: W holds dstE=dstM=4 with valE=0x100 and valM=0x55. Required: `reg4`=0x55 after the edge.
- Stall: assert `W_stall` with W holding dstE=1 and valE=7. Required: `reg1` unchanged, W outputs held, `retired` unchanged.
- Halt: m_stat=0100 enters W. Required: `proc_stat`=0100 and `halted`=1 on the following edge, no register write. A later AOK instruction does not clear `halted` or advance `retired`.
- Read RNONE and async reset: `d_srcB`=F gives `d_rvalB`=0. Pulsing `rst_n` low mid-run clears `reg0`..`reg14` without waiting for a clock edge.
